reginvalid_stall: RTL and testbench

Consumer side of the per-register invalid counters. Each cycle it reads the current invalid count of every architectural register and decides whether decode must stall on a source-operand hazard. It generates the per-register countdown value `nex` that is fed back into each counter. It sits between the register-invalid counter bank and the decode/issue stage, and also keeps stall statistics and a stall watchdog.

---
 rtl/reginvalid_stall.sv | 115 +++++++++++
 tb/tb_reginvalid_stall.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reginvalid_stall.sv
// Decode-side consumer of the per-register invalid counters. It detects source-operand
// hazards, drives stall and the per-register countdown feedback, and keeps stall statistics.
module reginvalid_stall #(
    parameter int NREG     = 8,
    parameter int CW       = 3,
    parameter int WD_LIMIT = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush_decode,
    input  logic                      memory_waiting,
    input  logic [NREG*CW-1:0]        cnt_in,
    input  logic                      issue_valid,
    input  logic                      rs_valid,
    input  logic [$clog2(NREG)-1:0]   rs,
    input  logic                      rt_valid,
    input  logic [$clog2(NREG)-1:0]   rt,
    output logic [NREG*2-1:0]         nex,
    output logic                      stall,
    output logic [15:0]               stall_count,
    output logic                      wd_err
);

    localparam int RW   = $clog2(NREG);
    localparam int RUNW = 5;
    localparam logic [RUNW:0] WD_LIM = (RUNW+1)'(WD_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt [NREG];
    logic              haz_rs;
    logic              haz_rt;
    logic              hazard;
    logic [RUNW-1:0]   run_cnt;
    logic [RUNW:0]     run_inc;

    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            cnt[i] = cnt_in[i*CW +: CW];
        end
    end

    assign haz_rs = issue_valid & rs_valid & (rs != '0) & (cnt[rs] != '0);
    assign haz_rt = issue_valid & rt_valid & (rt != '0) & (cnt[rt] != '0);
    assign hazard = haz_rs | haz_rt;

    assign stall = ~flush_decode & (hazard | (state == STALL) | (state == DRAIN));

    // Frozen counts clamp to the 2-bit range; draining counts step down, with 1 retiring to 0.
    always_comb begin
        logic [CW-1:0] c;
        logic [CW-1:0] dec;
        c   = '0;
        dec = '0;
        nex = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            c   = cnt[i];
            dec = c - CW'(1);
            if (memory_waiting) begin
                nex[i*2 +: 2] = (c >= CW'(3)) ? 2'd3 : c[1:0];
            end else if (c >= CW'(2)) begin
                nex[i*2 +: 2] = (dec >= CW'(3)) ? 2'd3 : dec[1:0];
            end else begin
                nex[i*2 +: 2] = 2'd0;
            end
        end
    end

    assign run_inc = {1'b0, run_cnt} + (RUNW+1)'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            stall_count <= '0;
            run_cnt     <= '0;
            wd_err      <= 1'b0;
        end else begin
            if (flush_decode) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE:    state <= hazard ? STALL : IDLE;
                    STALL,
                    DRAIN: begin
                        if (hazard)              state <= STALL;
                        else if (memory_waiting) state <= DRAIN;
                        else                     state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end

            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + 16'd1;
            end

            // Flush forces stall low, so the run counter clears on flush as well.
            if (!stall) begin
                run_cnt <= '0;
            end else if (run_cnt != '1) begin
                run_cnt <= run_inc[RUNW-1:0];
            end

            if (stall && (run_inc >= WD_LIM)) begin
                wd_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reginvalid_stall.sv
// Self-checking bench for reginvalid_stall: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of stall, countdown and statistics.
module tb_reginvalid_stall;

    localparam int NREG = 8;
    localparam int CW   = 3;
    localparam int WD   = 15;
    localparam int RW   = $clog2(NREG);

    logic                 clk;
    logic                 reset;
    logic                 flush_decode;
    logic                 memory_waiting;
    logic [NREG*CW-1:0]   cnt_in;
    logic                 issue_valid;
    logic                 rs_valid;
    logic [RW-1:0]        rs;
    logic                 rt_valid;
    logic [RW-1:0]        rt;
    logic [NREG*2-1:0]    nex;
    logic                 stall;
    logic [15:0]          stall_count;
    logic                 wd_err;

    int n_checks;
    int n_fail;

    // behavioural model
    int cnt_arr [NREG];
    bit m_held;      // stall carried over from the previous cycle
    int m_cnt;
    int m_run;
    bit m_wd;

    reginvalid_stall #(.NREG(NREG), .CW(CW), .WD_LIMIT(WD)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush_decode   (flush_decode),
        .memory_waiting (memory_waiting),
        .cnt_in         (cnt_in),
        .issue_valid    (issue_valid),
        .rs_valid       (rs_valid),
        .rs             (rs),
        .rt_valid       (rt_valid),
        .rt             (rt),
        .nex            (nex),
        .stall          (stall),
        .stall_count    (stall_count),
        .wd_err         (wd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pack();
        for (int i = 0; i < NREG; i++) cnt_in[i*CW +: CW] = CW'(cnt_arr[i]);
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < NREG; i++) cnt_arr[i] = 0;
        pack();
        flush_decode = 0; memory_waiting = 0; issue_valid = 0;
        rs_valid = 0; rs = '0; rt_valid = 0; rt = '0;
    endtask

    task automatic model_reset();
        m_held = 0; m_cnt = 0; m_run = 0; m_wd = 0;
    endtask

    function automatic bit m_hazard();
        bit a, b;
        a = rs_valid && (int'(rs) != 0) && (cnt_arr[int'(rs)] != 0);
        b = rt_valid && (int'(rt) != 0) && (cnt_arr[int'(rt)] != 0);
        return issue_valid && (a || b);
    endfunction

    function automatic bit exp_stall();
        return !flush_decode && (m_hazard() || m_held);
    endfunction

    function automatic logic [NREG*2-1:0] exp_nex();
        logic [NREG*2-1:0] v;
        int c, n;
        v = '0;
        for (int i = 1; i < NREG; i++) begin
            c = cnt_arr[i];
            if (c == 0)              n = 0;
            else if (memory_waiting) n = (c > 3) ? 3 : c;
            else                     n = (c >= 2) ? c - 1 : 0;
            v[i*2 +: 2] = 2'(n);
        end
        return v;
    endfunction

    // One clock: model advances on the rising edge, bench returns on the falling edge.
    task automatic tick();
        bit s, h;
        @(posedge clk);
        s = exp_stall();
        h = m_hazard();
        if (s && m_cnt < 65535) m_cnt++;
        if (s) begin
            m_run++;
            if (m_run >= WD) m_wd = 1;
        end else begin
            m_run = 0;
        end
        m_held = !flush_decode && (h || (m_held && memory_waiting));
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        issue_valid = 1; rs_valid = 1; rs = RW'(3); rt_valid = 1; rt = RW'(5);
        #1;
        n_checks++;
        if (stall_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", stall_count); end
        n_checks++;
        if (wd_err !== 1'b0) begin n_fail++; $display("FAIL reset_wd got=%b exp=0", wd_err); end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL idle_stall got=%b exp=0", stall); end
        n_checks++;
        if (nex !== '0) begin n_fail++; $display("FAIL idle_nex got=%h exp=0", nex); end
        // get into STALL, then reset asynchronously mid-cycle
        cnt_arr[3] = 3; pack();
        tick(); tick();
        #2 reset = 0;
        #1;
        model_reset();
        n_checks++;
        if (stall_count !== 16'd0) begin n_fail++; $display("FAIL async_reset_count got=%0d exp=0", stall_count); end
        n_checks++;
        if (wd_err !== 1'b0) begin n_fail++; $display("FAIL async_reset_wd got=%b exp=0", wd_err); end
        issue_valid = 0;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL async_reset_state got=%b exp=0", stall); end
        @(negedge clk);
        reset = 1;
        clear_inputs();
    endtask

    task automatic test_raw_hazard();
        bit exp_seq [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int seq_cnt [5] = '{3, 2, 1, 0, 0};
        do_reset();
        issue_valid = 1; rs_valid = 1; rs = RW'(3);
        for (int k = 0; k < 5; k++) begin
            cnt_arr[3] = seq_cnt[k]; pack();
            #1;
            n_checks++;
            if (stall !== exp_seq[k]) begin n_fail++; $display("FAIL raw_stall[%0d] got=%b exp=%b", k, stall, exp_seq[k]); end
            if (k == 0) begin
                n_checks++;
                if (nex[3*2 +: 2] !== 2'd2) begin n_fail++; $display("FAIL raw_nex3 got=%0d exp=2", nex[3*2 +: 2]); end
            end
            tick();
        end
        n_checks++;
        if (stall_count !== 16'd4) begin n_fail++; $display("FAIL raw_count got=%0d exp=4", stall_count); end
        clear_inputs();
    endtask

    task automatic test_reg0_invalid();
        clear_inputs();
        issue_valid = 1; rs_valid = 1; rs = '0;
        cnt_arr[0] = 4; pack();
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reg0_stall got=%b exp=0", stall); end
        n_checks++;
        if (nex[1:0] !== 2'd0) begin n_fail++; $display("FAIL reg0_nex got=%0d exp=0", nex[1:0]); end
        tick();
        rs_valid = 0; rt_valid = 0; rt = RW'(5);
        cnt_arr[5] = 2; pack();
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL rt_invalid_stall got=%b exp=0", stall); end
        n_checks++;
        if (nex[5*2 +: 2] !== 2'd1) begin n_fail++; $display("FAIL rt_invalid_nex5 got=%0d exp=1", nex[5*2 +: 2]); end
        tick();
        clear_inputs();
    endtask

    task automatic test_memwait();
        clear_inputs();
        memory_waiting = 1;
        cnt_arr[2] = 4; cnt_arr[4] = 1; pack();
        #1;
        n_checks++;
        if (nex[2*2 +: 2] !== 2'd3) begin n_fail++; $display("FAIL mw_nex2 got=%0d exp=3", nex[2*2 +: 2]); end
        n_checks++;
        if (nex[4*2 +: 2] !== 2'd1) begin n_fail++; $display("FAIL mw_nex4 got=%0d exp=1", nex[4*2 +: 2]); end
        issue_valid = 1; rs_valid = 1; rs = RW'(2);
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL mw_haz_stall got=%b exp=1", stall); end
        tick();
        rs_valid = 0;               // hazard gone, memory still waiting
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (stall !== 1'b1) begin n_fail++; $display("FAIL drain_hold[%0d] got=%b exp=1", k, stall); end
            tick();
        end
        memory_waiting = 0;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL drain_last got=%b exp=1", stall); end
        tick();
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL drain_exit got=%b exp=0", stall); end
        clear_inputs();
    endtask

    task automatic test_flush();
        clear_inputs();
        issue_valid = 1; rs_valid = 1; rs = RW'(6);
        cnt_arr[6] = 2; pack();
        tick();
        flush_decode = 1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%b exp=0", stall); end
        tick();
        flush_decode = 0;
        issue_valid = 0;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_idle got=%b exp=0", stall); end
        issue_valid = 1;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_reassert got=%b exp=1", stall); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_watchdog();
        bit e;
        do_reset();
        issue_valid = 1; rt_valid = 1; rt = RW'(7);
        cnt_arr[7] = 4; pack();
        for (int k = 1; k <= WD; k++) begin
            tick();
            e = (k >= WD);
            n_checks++;
            if (wd_err !== e) begin n_fail++; $display("FAIL wd_edge[%0d] got=%b exp=%b", k, wd_err, e); end
        end
        clear_inputs();
        tick(); tick(); tick();
        n_checks++;
        if (wd_err !== 1'b1) begin n_fail++; $display("FAIL wd_sticky got=%b exp=1", wd_err); end
    endtask

    task automatic test_random();
        logic [NREG*2-1:0] en;
        bit es;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NREG; i++)
                cnt_arr[i] = ($urandom_range(2) == 0) ? int'($urandom_range(1, 4)) : 0;
            pack();
            flush_decode   = ($urandom_range(7) == 0);
            memory_waiting = ($urandom_range(2) == 0);
            issue_valid    = ($urandom_range(3) != 0);
            rs_valid       = ($urandom_range(1) == 0);
            rt_valid       = ($urandom_range(1) == 0);
            rs             = RW'($urandom_range(NREG - 1));
            rt             = ($urandom_range(4) == 0) ? rs : RW'($urandom_range(NREG - 1));
            #1;
            es = exp_stall();
            en = exp_nex();
            n_checks++;
            if (stall !== es) begin n_fail++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", k, stall, es); end
            n_checks++;
            if (nex !== en) begin n_fail++; $display("FAIL rnd_nex[%0d] got=%h exp=%h", k, nex, en); end
            tick();
            n_checks++;
            if (stall_count !== 16'(m_cnt)) begin n_fail++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", k, stall_count, m_cnt); end
            n_checks++;
            if (wd_err !== m_wd) begin n_fail++; $display("FAIL rnd_wd[%0d] got=%b exp=%b", k, wd_err, m_wd); end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_saturation();
        issue_valid = 1; rs_valid = 1; rs = RW'(1);
        cnt_arr[1] = 3; pack();
        for (int k = 0; k < 65540; k++) tick();
        n_checks++;
        if (stall_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_count got=%h exp=ffff", stall_count); end
        n_checks++;
        if (stall_count !== 16'(m_cnt)) begin n_fail++; $display("FAIL sat_model got=%0d exp=%0d", stall_count, m_cnt); end
        tick();
        n_checks++;
        if (stall_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got=%h exp=ffff", stall_count); end
        clear_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        test_reset();
        test_raw_hazard();
        test_reg0_invalid();
        test_memwait();
        test_flush();
        test_watchdog();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
